// File: rtl/vx_hw_itr_ret_unit_if.sv
// Execute hardware-interrupt interface: execute drives the return-handler address and
// the JAL overload request; the return unit answers with captured return PCs and allHit.
interface VX_execute_hw_itr_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] retHandlerAddress;
    logic            overload_JAL;
    logic [XLEN-1:0] SIMTSchedulerRetPC;
    logic [XLEN-1:0] SIMTSchedulerRetPCw0;
    logic            commitSIMTSchedulerRetPC;
    logic            commitSIMTSchedulerRetPCw0;
    logic            allHit;
    logic [XLEN-1:0] WspawnPCplus4;
    logic            writeWspawnPCplus4;

    modport master (
        output retHandlerAddress, overload_JAL,
        input  SIMTSchedulerRetPC, SIMTSchedulerRetPCw0, commitSIMTSchedulerRetPC,
               commitSIMTSchedulerRetPCw0, allHit, WspawnPCplus4, writeWspawnPCplus4
    );

    modport slave (
        input  retHandlerAddress, overload_JAL,
        output SIMTSchedulerRetPC, SIMTSchedulerRetPCw0, commitSIMTSchedulerRetPC,
               commitSIMTSchedulerRetPCw0, allHit, WspawnPCplus4, writeWspawnPCplus4
    );
endinterface

// File: rtl/vx_hw_itr_ret_unit.sv
// Return unit for the execute hardware interrupt: captures redirected JAL return PCs,
// collects per-warp arrivals at the return handler and pulses allHit on full coverage.
module vx_hw_itr_ret_unit #(
    parameter int NUM_WARPS = 4,
    parameter int XLEN      = 32,
    localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    VX_execute_hw_itr_if.slave   hw_itr_if,
    input  logic                 jal_valid,
    input  logic [NW_BITS-1:0]   jal_wid,
    input  logic [XLEN-1:0]      jal_pc,
    input  logic                 wspawn_valid,
    input  logic [XLEN-1:0]      wspawn_pc,
    input  logic                 fetch_valid,
    input  logic [NW_BITS-1:0]   fetch_wid,
    input  logic [XLEN-1:0]      fetch_pc,
    input  logic [NUM_WARPS-1:0] active_warps
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    state_t               state_r;
    state_t               state_s;
    logic [NUM_WARPS-1:0] hitMask_r;
    logic [NUM_WARPS-1:0] hitMask_s;
    logic [NUM_WARPS-1:0] newHit_s;
    logic                 covered_s;
    logic                 jalFire_s;
    logic                 jalFireW0_s;

    logic [XLEN-1:0]      retPc_r;
    logic [XLEN-1:0]      retPcW0_r;
    logic                 commit_r;
    logic                 commitW0_r;
    logic                 allHit_r;
    logic [XLEN-1:0]      wspawnPc_r;
    logic                 wspawnWrite_r;

    // Decode this cycle's return-handler fetch into a one-hot warp mask and test coverage.
    always_comb begin
        newHit_s = {NUM_WARPS{1'b0}};
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (fetch_valid && (fetch_pc == hw_itr_if.retHandlerAddress)
                && (fetch_wid == NW_BITS'(i))) begin
                newHit_s[i] = 1'b1;
            end else begin
                newHit_s[i] = 1'b0;
            end
        end
        covered_s = (active_warps != {NUM_WARPS{1'b0}})
                    && ((active_warps & ~(hitMask_r | newHit_s)) == {NUM_WARPS{1'b0}});
    end

    // Next-state and hit-mask update; a falling overload_JAL outranks a completing hit.
    always_comb begin
        state_s   = state_r;
        hitMask_s = hitMask_r;
        case (state_r)
            IDLE: begin
                hitMask_s = {NUM_WARPS{1'b0}};
                if (hw_itr_if.overload_JAL) begin
                    state_s = TRACK;
                end else begin
                    state_s = IDLE;
                end
            end
            TRACK: begin
                if (!hw_itr_if.overload_JAL) begin
                    state_s   = IDLE;
                    hitMask_s = {NUM_WARPS{1'b0}};
                end else if (covered_s) begin
                    state_s   = DONE;
                    hitMask_s = hitMask_r | newHit_s;
                end else begin
                    state_s   = TRACK;
                    hitMask_s = hitMask_r | newHit_s;
                end
            end
            DONE: begin
                hitMask_s = {NUM_WARPS{1'b0}};
                if (hw_itr_if.overload_JAL) begin
                    state_s = TRACK;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s   = IDLE;
                hitMask_s = {NUM_WARPS{1'b0}};
            end
        endcase
    end

    // JAL capture qualifiers.
    always_comb begin
        jalFire_s   = hw_itr_if.overload_JAL && jal_valid;
        jalFireW0_s = jalFire_s && (jal_wid == {NW_BITS{1'b0}});
    end

    // FSM state, hit mask and allHit pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            hitMask_r <= {NUM_WARPS{1'b0}};
            allHit_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            hitMask_r <= hitMask_s;
            allHit_r  <= (state_s == DONE);
        end
    end

    // Return-PC capture; data holds between commits while the strobes are single-cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retPc_r       <= {XLEN{1'b0}};
            retPcW0_r     <= {XLEN{1'b0}};
            commit_r      <= 1'b0;
            commitW0_r    <= 1'b0;
            wspawnPc_r    <= {XLEN{1'b0}};
            wspawnWrite_r <= 1'b0;
        end else begin
            commit_r      <= jalFire_s;
            commitW0_r    <= jalFireW0_s;
            wspawnWrite_r <= wspawn_valid;
            if (jalFire_s) begin
                retPc_r <= jal_pc + PC_STEP;
            end
            if (jalFireW0_s) begin
                retPcW0_r <= jal_pc + PC_STEP;
            end
            if (wspawn_valid) begin
                wspawnPc_r <= wspawn_pc + PC_STEP;
            end
        end
    end

    assign hw_itr_if.SIMTSchedulerRetPC         = retPc_r;
    assign hw_itr_if.SIMTSchedulerRetPCw0       = retPcW0_r;
    assign hw_itr_if.commitSIMTSchedulerRetPC   = commit_r;
    assign hw_itr_if.commitSIMTSchedulerRetPCw0 = commitW0_r;
    assign hw_itr_if.allHit                     = allHit_r;
    assign hw_itr_if.WspawnPCplus4              = wspawnPc_r;
    assign hw_itr_if.writeWspawnPCplus4         = wspawnWrite_r;
endmodule

// File: tb/tb_vx_hw_itr_ret_unit.sv
// Bench for vx_hw_itr_ret_unit: directed scenarios plus a randomized run, all checked
// against a warp-set reference model of the interrupt-return protocol.
module tb_vx_hw_itr_ret_unit;
    localparam int NW = 4;

    logic          clk;
    logic          reset_n;
    logic          jal_valid;
    logic [1:0]    jal_wid;
    logic [31:0]   jal_pc;
    logic          wspawn_valid;
    logic [31:0]   wspawn_pc;
    logic          fetch_valid;
    logic [1:0]    fetch_wid;
    logic [31:0]   fetch_pc;
    logic [NW-1:0] active_warps;

    VX_execute_hw_itr_if #(.XLEN(32)) hwItrIf ();

    vx_hw_itr_ret_unit #(.NUM_WARPS(NW), .XLEN(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hw_itr_if    (hwItrIf.slave),
        .jal_valid    (jal_valid),
        .jal_wid      (jal_wid),
        .jal_pc       (jal_pc),
        .wspawn_valid (wspawn_valid),
        .wspawn_pc    (wspawn_pc),
        .fetch_valid  (fetch_valid),
        .fetch_wid    (fetch_wid),
        .fetch_pc     (fetch_pc),
        .active_warps (active_warps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: protocol phase (0 idle, 1 collecting, 2 complete) and arrived warps.
    int          mPhase;
    bit          mArrived [NW];
    logic [31:0] expRetPc, expRetPcW0, expWsp;
    bit          expCommit, expCommitW0, expWrite, expAllHit;

    task automatic model_reset();
        mPhase = 0;
        foreach (mArrived[i]) mArrived[i] = 1'b0;
        expRetPc = 32'd0; expRetPcW0 = 32'd0; expWsp = 32'd0;
        expCommit = 1'b0; expCommitW0 = 1'b0; expWrite = 1'b0; expAllHit = 1'b0;
    endtask

    task automatic idle_inputs();
        jal_valid = 1'b0; jal_wid = 2'd0; jal_pc = 32'd0;
        wspawn_valid = 1'b0; wspawn_pc = 32'd0;
        fetch_valid = 1'b0; fetch_wid = 2'd0; fetch_pc = 32'd0;
    endtask

    // Advance one clock: predict from the current inputs, then sample #1 after the edge.
    task automatic cycle();
        bit          ovl, nc, nc0, nw, everyone, anyActive;
        int          nextPhase;
        logic [31:0] nRet, nRet0, nWsp;
        ovl  = hwItrIf.overload_JAL;
        nc   = ovl && jal_valid;
        nc0  = nc && (jal_wid == 2'd0);
        nw   = wspawn_valid;
        nRet = nc ? jal_pc + 32'd4 : expRetPc;
        nRet0 = nc0 ? jal_pc + 32'd4 : expRetPcW0;
        nWsp = nw ? wspawn_pc + 32'd4 : expWsp;
        nextPhase = 0;
        if (mPhase == 1 && ovl) begin
            if (fetch_valid && fetch_pc == hwItrIf.retHandlerAddress) mArrived[fetch_wid] = 1'b1;
            everyone = 1'b1; anyActive = 1'b0;
            for (int i = 0; i < NW; i++) begin
                if (active_warps[i]) begin
                    anyActive = 1'b1;
                    if (!mArrived[i]) everyone = 1'b0;
                end
            end
            nextPhase = (everyone && anyActive) ? 2 : 1;
        end else begin
            foreach (mArrived[i]) mArrived[i] = 1'b0;
            nextPhase = ovl ? 1 : 0;
        end
        if (nextPhase == 2) foreach (mArrived[i]) mArrived[i] = 1'b0;
        @(posedge clk);
        #1;
        mPhase = nextPhase;
        expAllHit = (nextPhase == 2);
        expCommit = nc; expCommitW0 = nc0; expWrite = nw;
        expRetPc = nRet; expRetPcW0 = nRet0; expWsp = nWsp;
    endtask

    task automatic fetch_at(input logic [1:0] wid, input logic [31:0] pc);
        fetch_valid = 1'b1; fetch_wid = wid; fetch_pc = pc;
        cycle();
        fetch_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        hwItrIf.overload_JAL = 1'b0;
        hwItrIf.retHandlerAddress = 32'h100;
        active_warps = 4'b0000;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        if ({hwItrIf.SIMTSchedulerRetPC, hwItrIf.SIMTSchedulerRetPCw0, hwItrIf.WspawnPCplus4} !== 96'd0) begin
            nErrors++; $display("FAIL reset_data got %h %h %h want 0", hwItrIf.SIMTSchedulerRetPC,
                                hwItrIf.SIMTSchedulerRetPCw0, hwItrIf.WspawnPCplus4);
        end
        nChecks++;
        if ({hwItrIf.commitSIMTSchedulerRetPC, hwItrIf.commitSIMTSchedulerRetPCw0,
             hwItrIf.allHit, hwItrIf.writeWspawnPCplus4} !== 4'b0000) begin
            nErrors++; $display("FAIL reset_pulses got %b want 0000", {hwItrIf.commitSIMTSchedulerRetPC,
                                hwItrIf.commitSIMTSchedulerRetPCw0, hwItrIf.allHit, hwItrIf.writeWspawnPCplus4});
        end
        nChecks++;
    endtask

    task automatic test_jal_redirect();
        hwItrIf.overload_JAL = 1'b1;
        jal_valid = 1'b1; jal_wid = 2'd2; jal_pc = 32'h8000_0010;
        cycle();
        jal_valid = 1'b0;
        if (hwItrIf.SIMTSchedulerRetPC !== 32'h8000_0014 || expRetPc !== 32'h8000_0014) begin
            nErrors++; $display("FAIL jal_retpc got %h want 80000014", hwItrIf.SIMTSchedulerRetPC);
        end
        nChecks++;
        if (hwItrIf.commitSIMTSchedulerRetPC !== 1'b1 || hwItrIf.commitSIMTSchedulerRetPCw0 !== 1'b0) begin
            nErrors++; $display("FAIL jal_commit got %b%b want 10", hwItrIf.commitSIMTSchedulerRetPC,
                                hwItrIf.commitSIMTSchedulerRetPCw0);
        end
        nChecks++;
        if (hwItrIf.SIMTSchedulerRetPCw0 !== expRetPcW0) begin
            nErrors++; $display("FAIL jal_w0_hold got %h want %h", hwItrIf.SIMTSchedulerRetPCw0, expRetPcW0);
        end
        nChecks++;
        cycle();
        if (hwItrIf.commitSIMTSchedulerRetPC !== 1'b0 || hwItrIf.SIMTSchedulerRetPC !== 32'h8000_0014) begin
            nErrors++; $display("FAIL jal_one_cycle got %b %h want 0 80000014",
                                hwItrIf.commitSIMTSchedulerRetPC, hwItrIf.SIMTSchedulerRetPC);
        end
        nChecks++;
    endtask

    task automatic test_jal_w0_wrap();
        jal_valid = 1'b1; jal_wid = 2'd0; jal_pc = 32'hFFFF_FFFC;
        cycle();
        jal_valid = 1'b0;
        if (hwItrIf.SIMTSchedulerRetPC !== 32'd0 || hwItrIf.SIMTSchedulerRetPCw0 !== 32'd0) begin
            nErrors++; $display("FAIL w0_wrap got %h %h want 0 0", hwItrIf.SIMTSchedulerRetPC,
                                hwItrIf.SIMTSchedulerRetPCw0);
        end
        nChecks++;
        if (hwItrIf.commitSIMTSchedulerRetPC !== 1'b1 || hwItrIf.commitSIMTSchedulerRetPCw0 !== 1'b1) begin
            nErrors++; $display("FAIL w0_commits got %b%b want 11", hwItrIf.commitSIMTSchedulerRetPC,
                                hwItrIf.commitSIMTSchedulerRetPCw0);
        end
        nChecks++;
        cycle();
    endtask

    task automatic test_full_collect();
        logic [1:0] order [3] = '{2'd0, 2'd1, 2'd3};
        hwItrIf.retHandlerAddress = 32'h100;
        active_warps = 4'b1011;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 3; k++) begin
                fetch_at(order[k], 32'h100);
                if (hwItrIf.allHit !== expAllHit || expAllHit !== (k == 2)) begin
                    nErrors++; $display("FAIL collect_r%0d_k%0d got %b want %b", round, k,
                                        hwItrIf.allHit, (k == 2));
                end
                nChecks++;
                cycle();
                if (hwItrIf.allHit !== 1'b0) begin
                    nErrors++; $display("FAIL collect_gap_r%0d_k%0d got %b want 0", round, k, hwItrIf.allHit);
                end
                nChecks++;
            end
        end
        fetch_at(2'd0, 32'h100);
        if (hwItrIf.allHit !== 1'b0) begin
            nErrors++; $display("FAIL collect_no_retrigger got %b want 0", hwItrIf.allHit);
        end
        nChecks++;
        cycle();
    endtask

    task automatic test_abort();
        hwItrIf.overload_JAL = 1'b0;
        cycle();
        hwItrIf.overload_JAL = 1'b1;
        cycle();
        fetch_at(2'd0, 32'h100);
        fetch_at(2'd1, 32'h100);
        hwItrIf.overload_JAL = 1'b0;
        cycle();
        if (hwItrIf.allHit !== 1'b0) begin
            nErrors++; $display("FAIL abort_drop got %b want 0", hwItrIf.allHit);
        end
        nChecks++;
        hwItrIf.overload_JAL = 1'b1;
        cycle();
        fetch_at(2'd3, 32'h100);
        cycle();
        if (hwItrIf.allHit !== 1'b0 || expAllHit !== 1'b0) begin
            nErrors++; $display("FAIL abort_rearm got %b want 0", hwItrIf.allHit);
        end
        nChecks++;
        // completing hit in the same cycle overload_JAL falls
        fetch_at(2'd0, 32'h100);
        hwItrIf.overload_JAL = 1'b0;
        fetch_at(2'd1, 32'h100);
        if (hwItrIf.allHit !== 1'b0) begin
            nErrors++; $display("FAIL fall_priority got %b want 0", hwItrIf.allHit);
        end
        nChecks++;
    endtask

    task automatic test_wspawn();
        hwItrIf.overload_JAL = 1'b0;
        wspawn_valid = 1'b1; wspawn_pc = 32'h200;
        cycle();
        wspawn_valid = 1'b0;
        if (hwItrIf.WspawnPCplus4 !== 32'h204 || hwItrIf.writeWspawnPCplus4 !== 1'b1) begin
            nErrors++; $display("FAIL wspawn got %h %b want 204 1", hwItrIf.WspawnPCplus4,
                                hwItrIf.writeWspawnPCplus4);
        end
        nChecks++;
        cycle();
        if (hwItrIf.WspawnPCplus4 !== 32'h204 || hwItrIf.writeWspawnPCplus4 !== 1'b0) begin
            nErrors++; $display("FAIL wspawn_hold got %h %b want 204 0", hwItrIf.WspawnPCplus4,
                                hwItrIf.writeWspawnPCplus4);
        end
        nChecks++;
    endtask

    task automatic test_reset_mid();
        hwItrIf.overload_JAL = 1'b1;
        cycle();
        fetch_at(2'd0, 32'h100);
        fetch_at(2'd1, 32'h100);
        fetch_valid = 1'b1; fetch_wid = 2'd3; fetch_pc = 32'h100;
        jal_valid = 1'b1; jal_wid = 2'd0; jal_pc = 32'h40;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        if ({hwItrIf.SIMTSchedulerRetPC, hwItrIf.SIMTSchedulerRetPCw0, hwItrIf.WspawnPCplus4,
             hwItrIf.commitSIMTSchedulerRetPC, hwItrIf.commitSIMTSchedulerRetPCw0,
             hwItrIf.allHit, hwItrIf.writeWspawnPCplus4} !== 100'd0) begin
            nErrors++; $display("FAIL reset_mid_outputs got allHit=%b retpc=%h want all 0",
                                hwItrIf.allHit, hwItrIf.SIMTSchedulerRetPC);
        end
        nChecks++;
        reset_n = 1'b1;
        cycle();
        fetch_at(2'd3, 32'h100);
        if (hwItrIf.allHit !== expAllHit || hwItrIf.allHit !== 1'b0) begin
            nErrors++; $display("FAIL reset_mid_after got %b want 0", hwItrIf.allHit);
        end
        nChecks++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            hwItrIf.overload_JAL = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) active_warps = 4'($urandom);
            jal_valid = ($urandom_range(0, 3) == 0);
            jal_wid = 2'($urandom);
            jal_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            wspawn_valid = ($urandom_range(0, 4) == 0);
            wspawn_pc = $urandom;
            fetch_valid = ($urandom_range(0, 1) == 0);
            fetch_wid = 2'($urandom);
            fetch_pc = ($urandom_range(0, 3) != 0) ? hwItrIf.retHandlerAddress : $urandom;
            cycle();
            if (hwItrIf.allHit !== expAllHit) begin
                nErrors++; $display("FAIL rnd%0d_allHit got %b want %b", n, hwItrIf.allHit, expAllHit);
            end
            nChecks++;
            if (hwItrIf.commitSIMTSchedulerRetPC !== expCommit || hwItrIf.SIMTSchedulerRetPC !== expRetPc) begin
                nErrors++; $display("FAIL rnd%0d_ret got %b %h want %b %h", n, hwItrIf.commitSIMTSchedulerRetPC,
                                    hwItrIf.SIMTSchedulerRetPC, expCommit, expRetPc);
            end
            nChecks++;
            if (hwItrIf.commitSIMTSchedulerRetPCw0 !== expCommitW0 || hwItrIf.SIMTSchedulerRetPCw0 !== expRetPcW0) begin
                nErrors++; $display("FAIL rnd%0d_retw0 got %b %h want %b %h", n, hwItrIf.commitSIMTSchedulerRetPCw0,
                                    hwItrIf.SIMTSchedulerRetPCw0, expCommitW0, expRetPcW0);
            end
            nChecks++;
            if (hwItrIf.writeWspawnPCplus4 !== expWrite || hwItrIf.WspawnPCplus4 !== expWsp) begin
                nErrors++; $display("FAIL rnd%0d_wspawn got %b %h want %b %h", n, hwItrIf.writeWspawnPCplus4,
                                    hwItrIf.WspawnPCplus4, expWrite, expWsp);
            end
            nChecks++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_jal_redirect();
        test_jal_w0_wrap();
        test_full_collect();
        test_abort();
        test_wspawn();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule
